fir_capture: RTL and testbench

On-chip response capture buffer for the FIR datapath. It is the hardware reader paired with the filter's output stream. The block arms on command and triggers immediately or on a signed level crossing. It then records a programmable number of valid `fir_out` samples into internal RAM and streams them back out over a valid/ready interface. It sits beside `fir_top`, tapping `fir_out`, and replaces file-based capture for silicon/FPGA bring-up.

---
 rtl/fir_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_fir_capture.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_capture.sv
`default_nettype none
// ============================================================================
// Module   : fir_capture
// Purpose  : Triggered capture buffer for the FIR output stream; records a
//            programmable number of samples and replays them over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fir_capture #(
    parameter int D_W   = 12,
    parameter int DEPTH = 2048,
    parameter int A_W   = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic signed [D_W-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_mode,
    input  logic signed [D_W-1:0] trig_level,
    input  logic [A_W:0]          capture_len,
    output logic                  busy,
    output logic                  done,
    output logic signed [D_W-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    localparam logic [A_W:0] C_DEPTH = (A_W+1)'(DEPTH);
    localparam logic [A_W:0] C_ONE   = (A_W+1)'(1);

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic signed [D_W-1:0] level_q, level_d;
    logic signed [D_W-1:0] prev_q, prev_d;
    logic                  prev_seen_q, prev_seen_d;
    logic [A_W:0]          len_q, len_d;
    logic [A_W:0]          wr_ptr_q, wr_ptr_d;
    logic [A_W:0]          rd_ptr_q, rd_ptr_d;
    logic                  done_q, done_d;
    logic                  s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic                  sk_v_q, sk_v_d, sk_last_q, sk_last_d;
    logic [D_W-1:0]        sk_data_q, sk_data_d;
    logic                  out_v_q, out_v_d, out_last_q, out_last_d;
    logic [D_W-1:0]        out_data_q, out_data_d;
    logic [D_W-1:0]        mem_rdata_q;
    logic [D_W-1:0]        mem [DEPTH];

    logic                  we;
    logic [A_W-1:0]        waddr;
    logic                  trig;
    logic                  pop;
    logic                  issue;
    logic [1:0]            occ_after;
    logic [A_W:0]          eff_len;

    always_comb begin
        eff_len = ((capture_len == '0) || (capture_len > C_DEPTH)) ? C_DEPTH : capture_len;
        trig    = sample_valid &&
                  (!mode_q || (prev_seen_q && (prev_q < level_q) && (sample_in >= level_q)));
        pop     = out_v_q && rd_ready;
        // Output register, skid and in-flight RAM read together never exceed
        // two words, so a read issued now always has somewhere to land.
        occ_after = 2'(out_v_q) + 2'(sk_v_q) + 2'(s1_v_q) - 2'(pop);
        issue     = (state_q == S_READOUT) && (rd_ptr_q != len_q) && (occ_after < 2'd2);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        level_d     = level_q;
        prev_d      = prev_q;
        prev_seen_d = prev_seen_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = 1'b0;
        we          = 1'b0;
        waddr       = wr_ptr_q[A_W-1:0];
        s1_v_d      = issue;
        s1_last_d   = issue && (rd_ptr_q == (len_q - C_ONE));
        sk_v_d      = sk_v_q;
        sk_last_d   = sk_last_q;
        sk_data_d   = sk_data_q;
        out_v_d     = out_v_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (issue) begin
            rd_ptr_d = rd_ptr_q + C_ONE;
        end

        // Oldest word first: skid before the read that is just returning.
        if (!out_v_q || pop) begin
            if (sk_v_q) begin
                out_v_d    = 1'b1;
                out_data_d = sk_data_q;
                out_last_d = sk_last_q;
                sk_v_d     = s1_v_q;
                sk_data_d  = mem_rdata_q;
                sk_last_d  = s1_last_q;
            end else if (s1_v_q) begin
                out_v_d    = 1'b1;
                out_data_d = mem_rdata_q;
                out_last_d = s1_last_q;
            end else begin
                out_v_d    = 1'b0;
                out_last_d = 1'b0;
            end
        end else if (s1_v_q) begin
            sk_v_d    = 1'b1;
            sk_data_d = mem_rdata_q;
            sk_last_d = s1_last_q;
        end

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d     = S_ARMED;
                    mode_d      = trig_mode;
                    level_d     = trig_level;
                    len_d       = eff_len;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    prev_seen_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (sample_valid) begin
                    prev_d      = sample_in;
                    prev_seen_d = 1'b1;
                end
                if (trig) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = C_ONE;
                    if (len_q == C_ONE) begin
                        state_d = S_READOUT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (sample_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + C_ONE;
                    if (wr_ptr_d == len_q) begin
                        state_d = S_READOUT;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READOUT: begin
                if (pop && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            we         = 1'b0;
            s1_v_d     = 1'b0;
            sk_v_d     = 1'b0;
            out_v_d    = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (we && reset) begin
            mem[waddr] <= sample_in;
        end
        mem_rdata_q <= mem[rd_ptr_q[A_W-1:0]];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            level_q     <= '0;
            prev_q      <= '0;
            prev_seen_q <= 1'b0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            sk_v_q      <= 1'b0;
            sk_last_q   <= 1'b0;
            sk_data_q   <= '0;
            out_v_q     <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            prev_seen_q <= prev_seen_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            sk_v_q      <= sk_v_d;
            sk_last_q   <= sk_last_d;
            sk_data_q   <= sk_data_d;
            out_v_q     <= out_v_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign rd_valid = out_v_q;
    assign rd_last  = out_last_q;
    assign rd_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_capture
// Purpose  : Directed, self-checking bench for fir_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_capture;

    logic        clock;
    logic        reset;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        arm;
    logic        abort;
    logic        trig_mode;
    logic [11:0] trig_level;
    logic [11:0] capture_len;
    logic        busy;
    logic        done;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;

    fir_capture dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .capture_len  (capture_len),
        .busy         (busy),
        .done         (done),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        logic [11:0] level;
        logic [11:0] clen;
        int          nstim;
        logic [11:0] stim [8];
        int          nexp;
        logic [11:0] expv [8];
    } vec_t;

    vec_t        tbl [6];
    logic [11:0] stim_q [$];
    logic [11:0] exp_q  [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Arm, stream stim_q, drain the readout and compare with exp_q.
    task automatic run(input string name, input logic mode, input logic [11:0] lvl,
                       input logic [11:0] clen, input bit gap, input bit rnd, input bit arm_ro);
        int   cyc, idx, nwords, done_cnt, done_cyc, first_v, last_cyc;
        int   data_err, last_err, stall_err;
        bit   finished, ph, prev_stall, rdy;
        logic [11:0] prev_data;
        logic        prev_last;
        cyc = 0; idx = 0; nwords = 0; done_cnt = 0; done_cyc = -100; first_v = -1;
        last_cyc = 0; data_err = 0; last_err = 0; stall_err = 0;
        finished = 0; ph = 1; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        @(negedge clock);
        arm = 1'b1; trig_mode = mode; trig_level = lvl; capture_len = clen; rd_ready = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        while (!finished && cyc < 20000) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            if (rd_valid && first_v < 0) first_v = cyc;
            if (prev_stall && (rd_data !== prev_data || rd_last !== prev_last)) stall_err++;
            rdy      = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            rd_ready = rdy;
            arm      = arm_ro && done;
            if (rd_valid && rdy) begin
                if (nwords < exp_q.size()) begin
                    if (rd_data !== exp_q[nwords]) data_err++;
                end else begin
                    data_err++;
                end
                if (rd_last !== (nwords == exp_q.size() - 1)) last_err++;
                if (rd_last) begin
                    finished = 1;
                    last_cyc = cyc;
                end
                nwords++;
            end
            prev_stall = rd_valid && !rdy;
            prev_data  = rd_data;
            prev_last  = rd_last;
            if (idx < stim_q.size() && (!gap || ph)) begin
                sample_in    = stim_q[idx];
                sample_valid = 1'b1;
                idx++;
            end else begin
                sample_valid = 1'b0;
            end
            ph = !ph;
            @(negedge clock);
            cyc++;
        end
        arm = 1'b0; sample_valid = 1'b0;
        check({name, "_finished"}, int'(finished), 1);
        check({name, "_words"}, nwords, exp_q.size());
        check({name, "_data_errs"}, data_err, 0);
        check({name, "_last_errs"}, last_err, 0);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_done_to_valid"}, first_v - done_cyc, 2);
        if (rnd) check({name, "_stall_errs"}, stall_err, 0);
        else     check({name, "_burst_len"}, last_cyc - first_v + 1, exp_q.size());
        check({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int          hs, bnd, dcnt;
        reset = 1'b0; sample_in = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; trig_level = '0; capture_len = '0; rd_ready = 1'b0;

        tbl[0] = '{mode: 1'b0, level: 12'h000, clen: 12'd8, nstim: 8,
                   stim: '{12'h7FF, 0, 0, 0, 0, 0, 0, 0}, nexp: 8,
                   expv: '{12'h7FF, 0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{mode: 1'b1, level: 12'h000, clen: 12'd4, nstim: 7,
                   stim: '{12'hFFB, 12'hFFF, 12'h000, 12'h003, 12'h007, 12'h002, 12'hFFD, 0}, nexp: 4,
                   expv: '{12'h000, 12'h003, 12'h007, 12'h002, 0, 0, 0, 0}};
        tbl[2] = '{mode: 1'b1, level: 12'h000, clen: 12'd2, nstim: 5,
                   stim: '{12'h000, 12'h005, 12'hFFE, 12'h001, 12'h004, 0, 0, 0}, nexp: 2,
                   expv: '{12'h001, 12'h004, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{mode: 1'b0, level: 12'h000, clen: 12'd1, nstim: 2,
                   stim: '{12'h123, 12'h456, 0, 0, 0, 0, 0, 0}, nexp: 1,
                   expv: '{12'h123, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{mode: 1'b1, level: 12'hF9C, clen: 12'd3, nstim: 6,
                   stim: '{12'hF38, 12'hF6A, 12'hF9C, 12'hFCE, 12'h032, 12'h03C, 0, 0}, nexp: 3,
                   expv: '{12'hF9C, 12'hFCE, 12'h032, 0, 0, 0, 0, 0}};
        tbl[5] = '{mode: 1'b0, level: 12'h000, clen: 12'd3, nstim: 4,
                   stim: '{12'h800, 12'h7FF, 12'h001, 12'h555, 0, 0, 0, 0}, nexp: 3,
                   expv: '{12'h800, 12'h7FF, 12'h001, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clock);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_last", int'(rd_last), 0);
        check("reset_rd_data", int'(rd_data), 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            stim_q.delete(); exp_q.delete();
            for (int k = 0; k < tbl[i].nstim; k++) stim_q.push_back(tbl[i].stim[k]);
            for (int k = 0; k < tbl[i].nexp; k++)  exp_q.push_back(tbl[i].expv[k]);
            run($sformatf("vec%0d", i), tbl[i].mode, tbl[i].level, tbl[i].clen, 1'b0, 1'b0, 1'b0);
        end

        // Backpressure with a ramp
        stim_q.delete(); exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            stim_q.push_back(12'(k)); exp_q.push_back(12'(k));
        end
        run("backpressure", 1'b0, 12'h000, 12'd16, 1'b0, 1'b1, 1'b0);

        // Arm during readout must be ignored
        stim_q.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back(12'(k + 40)); exp_q.push_back(12'(k + 40));
        end
        run("arm_in_readout", 1'b0, 12'h000, 12'd4, 1'b0, 1'b0, 1'b1);

        // Full depth with capture_len = 0 and 50% input duty
        stim_q.delete(); exp_q.delete();
        for (int k = 0; k < 2048; k++) begin
            stim_q.push_back(12'(k * 3 + 1)); exp_q.push_back(12'(k * 3 + 1));
        end
        run("full_depth_gapped", 1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0);

        // Abort mid-capture
        @(negedge clock);
        arm = 1'b1; trig_mode = 1'b0; capture_len = 12'd8;
        @(negedge clock);
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample_in = 12'(k + 1); sample_valid = 1'b1;
            @(negedge clock);
        end
        check("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0; sample_valid = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rd_valid", int'(rd_valid), 0);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy || rd_valid) dcnt++;
            @(negedge clock);
        end
        check("abort_quiet", dcnt, 0);

        // Arm and abort together from IDLE
        arm = 1'b1; abort = 1'b1; capture_len = 12'd4;
        @(negedge clock);
        arm = 1'b0; abort = 1'b0;
        check("arm_abort_busy", int'(busy), 0);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            sample_in = 12'h111; sample_valid = 1'b1;
            @(negedge clock);
            if (busy || done) dcnt++;
        end
        sample_valid = 1'b0;
        check("arm_abort_idle", dcnt, 0);

        // Reset mid-readout after three words
        arm = 1'b1; trig_mode = 1'b0; capture_len = 12'd8; rd_ready = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample_in = 12'(k + 10); sample_valid = 1'b1;
            @(negedge clock);
        end
        sample_valid = 1'b0;
        hs = 0; bnd = 0;
        while (hs < 3 && bnd < 50) begin
            if (rd_valid) hs++;
            @(negedge clock);
            bnd++;
        end
        check("rst_ro_words_seen", hs, 3);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ro_busy", int'(busy), 0);
        check("rst_ro_rd_valid", int'(rd_valid), 0);
        check("rst_ro_rd_last", int'(rd_last), 0);
        check("rst_ro_rd_data", int'(rd_data), 0);
        @(negedge clock);
        reset = 1'b1;
        check("rst_ro_done", int'(done), 0);
        @(negedge clock);
        check("rst_ro_idle", int'(busy), 0);

        stim_q.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back(12'((k + 1) * 256)); exp_q.push_back(12'((k + 1) * 256));
        end
        run("after_reset", 1'b0, 12'h000, 12'd4, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
